// File: rtl/dac_sweep_test_if.sv
// DAC-side pin bundle for the dac_sweep_test bring-up block: LVDS data/clock/strobe,
// SPI configuration port and DAC hardware reset.
interface dac_sweep_test_if;
  logic [15:0] D_out_p;
  logic [15:0] D_out_n;
  logic        CLK_out_p;
  logic        CLK_out_n;
  logic        DCI_out_p;
  logic        DCI_out_n;
  logic        csb;
  logic        sclk;
  logic        sdio;
  logic        sdo;
  logic        rst_out;

  modport master (
    output D_out_p, D_out_n, CLK_out_p, CLK_out_n, DCI_out_p, DCI_out_n,
    output csb, sclk, sdio, rst_out,
    input  sdo
  );

  modport slave (
    input  D_out_p, D_out_n, CLK_out_p, CLK_out_n, DCI_out_p, DCI_out_n,
    input  csb, sclk, sdio, rst_out,
    output sdo
  );
endinterface

// File: rtl/dac_sweep_test.sv
// DAC bring-up stimulus: hardware reset pulse, two-frame SPI config, then an interleaved ramp.
// Optional macro DAC_SWEEP_TRIANGLE_EN turns the sawtooth ramp into a saturating triangle.
module dac_sweep_test #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter logic [15:0] CFG_WORD0     = 16'h0200,
  parameter logic [15:0] CFG_WORD1     = 16'h0300,
  parameter logic [15:0] STEP          = 16'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  dac_sweep_test_if.master dac
);

  localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] SPI_END     = 16'd64;
  localparam logic [15:0] GAP_LAST    = 16'd3;

  typedef enum logic [2:0] {S_RST, S_SETTLE, S_SPI, S_GAP, S_SWEEP} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        frame, frame_nxt;
  logic [15:0] r, r_nxt;
  logic        up, up_nxt;
  logic        run, run_nxt;
  logic [15:0] d_p, d_n, d_nxt;
  logic        tgl_p, tgl_n, tgl_nxt;
  logic        csb_q, csb_nxt;
  logic        sclk_q, sclk_nxt;
  logic        sdio_q, sdio_nxt;
  logic        rst_out_q, rst_out_nxt;
  logic [15:0] word;
  logic [3:0]  bit_idx;
  logic [16:0] ramp;
  logic        sdo_unused;

  assign sdo_unused = dac.sdo;

  // Returns {direction_up, next_r}
  function automatic logic [16:0] ramp_next(input logic [15:0] cur, input logic dir_up);
`ifdef DAC_SWEEP_TRIANGLE_EN
    logic [16:0] sum;
    sum = {1'b0, cur} + {1'b0, STEP};
    if (dir_up) begin
      if (sum[16]) return {1'b0, 16'hFFFF};
      else         return {1'b1, sum[15:0]};
    end else begin
      if (cur < STEP) return {1'b1, 16'h0000};
      else            return {1'b0, cur - STEP};
    end
`else
    return {dir_up, cur + STEP};
`endif
  endfunction

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    frame_nxt   = frame;
    r_nxt       = r;
    up_nxt      = up;
    run_nxt     = run;
    d_nxt       = '0;
    tgl_nxt     = ~tgl_p;
    csb_nxt     = 1'b1;
    sclk_nxt    = 1'b0;
    sdio_nxt    = 1'b0;
    rst_out_nxt = 1'b0;
    ramp        = '0;
    word        = frame ? CFG_WORD1 : CFG_WORD0;
    bit_idx     = '0;

    case (state)
      S_RST: begin
        if (cnt == RST_LAST) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = '0;
        end else begin
          rst_out_nxt = 1'b1;
          cnt_nxt     = cnt + 16'd1;
        end
      end
      S_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_nxt = S_SPI;
          cnt_nxt   = '0;
          csb_nxt   = 1'b0;
          sdio_nxt  = CFG_WORD0[15];
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      S_SPI: begin
        // cnt counts clk ticks in the frame; bit k occupies ticks 4k..4k+3, sclk high on 4k+2/4k+3
        if (cnt == SPI_END) begin
          cnt_nxt = '0;
          if (frame) begin
            state_nxt = S_SWEEP;
            r_nxt     = '0;
            up_nxt    = 1'b1;
            run_nxt   = 1'b0;
          end else begin
            state_nxt = S_GAP;
          end
        end else begin
          csb_nxt = 1'b0;
          cnt_nxt = cnt + 16'd1;
          if (cnt_nxt < SPI_END) begin
            bit_idx  = ~cnt_nxt[5:2];
            sclk_nxt = cnt_nxt[1];
            sdio_nxt = word[bit_idx];
          end
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = S_SPI;
          frame_nxt = 1'b1;
          cnt_nxt   = '0;
          csb_nxt   = 1'b0;
          sdio_nxt  = CFG_WORD1[15];
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      S_SWEEP: begin
        // Output only starts on a channel-A slot so every pair is (r, ~r)
        if (tgl_nxt) begin
          d_nxt   = r;
          run_nxt = 1'b1;
        end else if (run) begin
          d_nxt  = ~r;
          ramp   = ramp_next(r, up);
          r_nxt  = ramp[15:0];
          up_nxt = ramp[16];
        end
      end
      default: state_nxt = S_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_RST;
      cnt       <= '0;
      frame     <= 1'b0;
      r         <= '0;
      up        <= 1'b1;
      run       <= 1'b0;
      d_p       <= '0;
      d_n       <= '1;
      tgl_p     <= 1'b0;
      tgl_n     <= 1'b1;
      csb_q     <= 1'b1;
      sclk_q    <= 1'b0;
      sdio_q    <= 1'b0;
      rst_out_q <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      frame     <= frame_nxt;
      r         <= r_nxt;
      up        <= up_nxt;
      run       <= run_nxt;
      d_p       <= d_nxt;
      d_n       <= ~d_nxt;
      tgl_p     <= tgl_nxt;
      tgl_n     <= ~tgl_nxt;
      csb_q     <= csb_nxt;
      sclk_q    <= sclk_nxt;
      sdio_q    <= sdio_nxt;
      rst_out_q <= rst_out_nxt;
    end
  end

  assign dac.D_out_p   = d_p;
  assign dac.D_out_n   = d_n;
  assign dac.CLK_out_p = tgl_p;
  assign dac.CLK_out_n = tgl_n;
  assign dac.DCI_out_p = tgl_p;
  assign dac.DCI_out_n = tgl_n;
  assign dac.csb       = csb_q;
  assign dac.sclk      = sclk_q;
  assign dac.sdio      = sdio_q;
  assign dac.rst_out   = rst_out_q;

endmodule

// File: tb/tb_dac_sweep_test.sv
// Directed bench for dac_sweep_test: reset values, reset/settle timing, SPI frames,
// sawtooth ramp, large-step wrap (or triangle with DAC_SWEEP_TRIANGLE_EN) and mid-frame abort.
module tb_dac_sweep_test;
  logic clk;
  logic rst_n;
  logic rst_n_w;
  int   checks;
  int   errors;

  dac_sweep_test_if bus ();
  dac_sweep_test_if bus_w ();

  assign bus.sdo   = 1'b0;
  assign bus_w.sdo = 1'b0;

  dac_sweep_test dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dac   (bus)
  );

  dac_sweep_test #(.STEP(16'h4000)) dut_w (
    .clk   (clk),
    .rst_n (rst_n_w),
    .dac   (bus_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n   = 1'b0;
    rst_n_w = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.D_out_p !== 16'h0000) begin errors++; $display("FAIL rst_d_p: got %h expected 0000", bus.D_out_p); end
    checks++; if (bus.D_out_n !== 16'hFFFF) begin errors++; $display("FAIL rst_d_n: got %h expected ffff", bus.D_out_n); end
    checks++; if (bus.csb !== 1'b1) begin errors++; $display("FAIL rst_csb: got %b expected 1", bus.csb); end
    checks++; if (bus.rst_out !== 1'b1) begin errors++; $display("FAIL rst_rst_out: got %b expected 1", bus.rst_out); end
    checks++; if (bus.CLK_out_p !== 1'b0) begin errors++; $display("FAIL rst_clk_p: got %b expected 0", bus.CLK_out_p); end
    checks++; if (bus.CLK_out_n !== 1'b1) begin errors++; $display("FAIL rst_clk_n: got %b expected 1", bus.CLK_out_n); end
    checks++; if (bus.DCI_out_p !== 1'b0) begin errors++; $display("FAIL rst_dci_p: got %b expected 0", bus.DCI_out_p); end
    checks++; if (bus.sclk !== 1'b0 || bus.sdio !== 1'b0) begin errors++; $display("FAIL rst_spi: got sclk %b sdio %b expected 0 0", bus.sclk, bus.sdio); end
  endtask

  task automatic test_rst_timing();
    int n;
    int m;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); @(negedge clk);
      n++;
      if (bus.rst_out === 1'b0) break;
    end
    checks++; if (n != 16) begin errors++; $display("FAIL rst_out_len: got %0d expected 16", n); end
    m = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); @(negedge clk);
      m++;
      if (bus.csb === 1'b0) break;
    end
    checks++; if (m != 16) begin errors++; $display("FAIL settle_len: got %0d expected 16", m); end
    checks++; if (bus.CLK_out_p !== 1'b0) begin errors++; $display("FAIL clk_phase: got %b expected 0", bus.CLK_out_p); end
  endtask

  // Entered on the sample where csb has just fallen for frame 0
  task automatic test_spi();
    logic [15:0] word;
    logic [15:0] exp_word;
    logic        prev_sclk;
    logic        prev_sdio;
    int          pulses;
    int          unstable;
    int          gap;
    for (int f = 0; f < 2; f++) begin
      exp_word  = (f == 0) ? 16'h0200 : 16'h0300;
      word      = '0;
      pulses    = 0;
      unstable  = 0;
      prev_sclk = bus.sclk;
      prev_sdio = bus.sdio;
      for (int i = 0; i < 200; i++) begin
        @(posedge clk); @(negedge clk);
        if (bus.csb === 1'b1) break;
        if (bus.sclk === 1'b1 && prev_sclk === 1'b0) begin
          word = {word[14:0], bus.sdio};
          pulses++;
          if (bus.sdio !== prev_sdio) unstable++;
        end
        prev_sclk = bus.sclk;
        prev_sdio = bus.sdio;
      end
      checks++; if (word !== exp_word) begin errors++; $display("FAIL spi_word%0d: got %h expected %h", f, word, exp_word); end
      checks++; if (pulses != 16) begin errors++; $display("FAIL spi_pulses%0d: got %0d expected 16", f, pulses); end
      checks++; if (unstable != 0) begin errors++; $display("FAIL spi_sdio_stable%0d: got %0d changes expected 0", f, unstable); end
      checks++; if (prev_sclk !== 1'b0) begin errors++; $display("FAIL spi_sclk_low_before_csb%0d: got %b expected 0", f, prev_sclk); end
      if (f == 0) begin
        gap = 1;
        for (int i = 0; i < 50; i++) begin
          @(posedge clk); @(negedge clk);
          if (bus.csb === 1'b0) break;
          gap++;
        end
        checks++; if (gap != 4) begin errors++; $display("FAIL spi_gap: got %0d expected 4", gap); end
      end
    end
  endtask

  // Entered on the sample where csb rose after frame 1 (sweep entry)
  task automatic test_sweep();
    logic [15:0] exp_a;
    logic        prev_dci;
    bit          have_a;
    int          pairs;
    exp_a    = 16'h0000;
    have_a   = 1'b0;
    pairs    = 0;
    prev_dci = bus.DCI_out_p;
    for (int i = 0; i < 200 && pairs < 20; i++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (bus.DCI_out_p === prev_dci) begin errors++; $display("FAIL dci_toggle: got %b expected %b", bus.DCI_out_p, ~prev_dci); end
      checks++; if (bus.CLK_out_p !== bus.DCI_out_p || bus.CLK_out_n !== ~bus.DCI_out_p) begin errors++; $display("FAIL clk_dci_phase: got clk %b dci %b", bus.CLK_out_p, bus.DCI_out_p); end
      checks++; if (bus.csb !== 1'b1 || bus.rst_out !== 1'b0) begin errors++; $display("FAIL sweep_ctrl: got csb %b rst_out %b expected 1 0", bus.csb, bus.rst_out); end
      prev_dci = bus.DCI_out_p;
      if (bus.DCI_out_p === 1'b1) begin
        checks++; if (bus.D_out_p !== exp_a) begin errors++; $display("FAIL saw_a: got %h expected %h", bus.D_out_p, exp_a); end
        have_a = 1'b1;
      end else if (have_a) begin
        checks++; if (bus.D_out_p !== ~exp_a) begin errors++; $display("FAIL saw_b: got %h expected %h", bus.D_out_p, ~exp_a); end
        checks++; if (bus.D_out_n !== exp_a) begin errors++; $display("FAIL saw_b_n: got %h expected %h", bus.D_out_n, exp_a); end
        exp_a  = exp_a + 16'd1;
        have_a = 1'b0;
        pairs++;
      end
    end
    checks++; if (pairs != 20) begin errors++; $display("FAIL saw_pairs: got %0d expected 20", pairs); end
  endtask

  task automatic test_wrap();
    logic [15:0] tbl [10];
    logic        prev_csb;
    int          rises;
    int          idx;
    bit          have_a;
`ifdef DAC_SWEEP_TRIANGLE_EN
    tbl = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'hFFFF, 16'hBFFF, 16'h7FFF, 16'h3FFF, 16'h0000, 16'h4000};
`else
    tbl = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h0000, 16'h4000};
`endif
    rst_n_w  = 1'b1;
    rises    = 0;
    prev_csb = bus_w.csb;
    for (int i = 0; i < 600 && rises < 2; i++) begin
      @(posedge clk); @(negedge clk);
      if (prev_csb === 1'b0 && bus_w.csb === 1'b1) rises++;
      prev_csb = bus_w.csb;
    end
    checks++;
    if (rises != 2) begin
      errors++; $display("FAIL wrap_reach_sweep: got %0d csb rises expected 2", rises);
    end else begin
      idx    = 0;
      have_a = 1'b0;
      for (int i = 0; i < 100 && idx < 10; i++) begin
        @(posedge clk); @(negedge clk);
        if (bus_w.DCI_out_p === 1'b1) begin
          checks++; if (bus_w.D_out_p !== tbl[idx]) begin errors++; $display("FAIL wrap_a%0d: got %h expected %h", idx, bus_w.D_out_p, tbl[idx]); end
          have_a = 1'b1;
        end else if (have_a) begin
          checks++; if (bus_w.D_out_p !== ~tbl[idx]) begin errors++; $display("FAIL wrap_b%0d: got %h expected %h", idx, bus_w.D_out_p, ~tbl[idx]); end
          idx++;
          have_a = 1'b0;
        end
      end
      checks++; if (idx != 10) begin errors++; $display("FAIL wrap_pairs: got %0d expected 10", idx); end
    end
  endtask

  task automatic test_abort();
    int          n;
    int          m;
    logic [15:0] word;
    logic        prev_sclk;
    int          pulses;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); @(negedge clk);
      m++;
      if (bus.csb === 1'b0) break;
    end
    checks++; if (m != 32) begin errors++; $display("FAIL abort_first_frame_start: got %0d expected 32", m); end
    repeat (20) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (bus.csb !== 1'b1) begin errors++; $display("FAIL abort_csb: got %b expected 1", bus.csb); end
    checks++; if (bus.sclk !== 1'b0) begin errors++; $display("FAIL abort_sclk: got %b expected 0", bus.sclk); end
    checks++; if (bus.rst_out !== 1'b1) begin errors++; $display("FAIL abort_rst_out: got %b expected 1", bus.rst_out); end
    checks++; if (bus.D_out_p !== 16'h0000 || bus.CLK_out_p !== 1'b0) begin errors++; $display("FAIL abort_data: got d %h clk %b expected 0000 0", bus.D_out_p, bus.CLK_out_p); end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); @(negedge clk);
      n++;
      if (bus.rst_out === 1'b0) break;
    end
    checks++; if (n != 16) begin errors++; $display("FAIL abort_rst_out_len: got %0d expected 16", n); end
    m = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); @(negedge clk);
      m++;
      if (bus.csb === 1'b0) break;
    end
    checks++; if (m != 16) begin errors++; $display("FAIL abort_settle_len: got %0d expected 16", m); end
    word      = '0;
    pulses    = 0;
    prev_sclk = bus.sclk;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); @(negedge clk);
      if (bus.csb === 1'b1) break;
      if (bus.sclk === 1'b1 && prev_sclk === 1'b0) begin
        word = {word[14:0], bus.sdio};
        pulses++;
      end
      prev_sclk = bus.sclk;
    end
    checks++; if (word !== 16'h0200 || pulses != 16) begin errors++; $display("FAIL abort_frame0: got %h/%0d expected 0200/16", word, pulses); end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    rst_n_w = 1'b0;
    test_reset();
    test_rst_timing();
    test_spi();
    test_sweep();
    test_wrap();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
